// File: rtl/pool_pkg.sv
// Shared types and constants for the pool-table sprite position path.
// Slot map: 0-14 balls 1-15, 15 cue ball, 16 pool cue 1.
package pool_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ARMED   = 2'd1,
    SWAP    = 2'd2
  } pos_state_t;

  localparam int NUM_OBJ_DEF = 17;
  localparam int COORD_W_DEF = 10;
  localparam int CUEBALL_ID  = 15;
  localparam int P1CUE_ID    = 16;
  localparam int V_VISIBLE   = 480;

  localparam logic [COORD_W_DEF-1:0] HIDE = 10'h3FF;

endpackage

// File: rtl/vblank_detect.sv
// One-cycle registered pulse on the first cycle that the
// raster reaches column 0 of the first non-visible line.
module vblank_detect #(
  parameter int COORD_W   = 10,
  parameter int V_VISIBLE = 480
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  output logic               vblank_start
);

  logic w_match;
  logic r_prev;
  logic r_vbs;

  assign w_match = (draw_y == COORD_W'(V_VISIBLE))
                && (draw_x == '0);

  // a match held over several cycles fires only once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= 1'b0;
      r_vbs  <= 1'b0;
    end else begin
      r_prev <= w_match;
      r_vbs  <= w_match & ~r_prev;
    end
  end

  assign vblank_start = r_vbs;

endmodule

// File: rtl/sprite_pos_writer.sv
// Double-buffered object coordinate block: writes land in a shadow
// bank, a commit arms a copy to the active bank at the next vblank.
module sprite_pos_writer #(
  parameter int NUM_OBJ   = pool_pkg::NUM_OBJ_DEF,
  parameter int COORD_W   = pool_pkg::COORD_W_DEF,
  parameter int V_VISIBLE = pool_pkg::V_VISIBLE,
  parameter logic [COORD_W-1:0] HIDE = pool_pkg::HIDE
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [4:0]                 wr_id,
  input  logic [COORD_W-1:0]         wr_x,
  input  logic [COORD_W-1:0]         wr_y,
  input  logic [2:0]                 wr_dir,
  input  logic                       commit,
  input  logic [COORD_W-1:0]         draw_x,
  input  logic [COORD_W-1:0]         draw_y,
  output logic [NUM_OBJ*COORD_W-1:0] pos_x,
  output logic [NUM_OBJ*COORD_W-1:0] pos_y,
  output logic [2:0]                 direction,
  output logic                       hw_sig,
  output logic                       pending,
  output logic                       bad_id
);

  import pool_pkg::*;

  localparam logic [4:0] ID_LIM = 5'(NUM_OBJ);
  localparam logic [4:0] CUE_ID = 5'(P1CUE_ID);

  pos_state_t r_state;

  logic [COORD_W-1:0] r_sh_x [NUM_OBJ];
  logic [COORD_W-1:0] r_sh_y [NUM_OBJ];
  logic [2:0]         r_sh_dir;

  logic [NUM_OBJ*COORD_W-1:0] r_pos_x;
  logic [NUM_OBJ*COORD_W-1:0] r_pos_y;
  logic [2:0]                 r_dir;
  logic                       r_hw_sig;
  logic                       r_bad_id;

  logic w_vblank_start;
  logic w_wr_fire;
  logic w_id_ok;

  vblank_detect #(
    .COORD_W   (COORD_W),
    .V_VISIBLE (V_VISIBLE)
  ) u_vblank (
    .clk          (clk),
    .reset_n      (reset_n),
    .draw_x       (draw_x),
    .draw_y       (draw_y),
    .vblank_start (w_vblank_start)
  );

  assign w_wr_fire = wr_valid && (r_state == COLLECT);
  assign w_id_ok   = wr_id < ID_LIM;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= COLLECT;
      r_sh_dir <= 3'd0;
      r_pos_x  <= {NUM_OBJ{HIDE}};
      r_pos_y  <= {NUM_OBJ{HIDE}};
      r_dir    <= 3'd0;
      r_hw_sig <= 1'b0;
      r_bad_id <= 1'b0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        r_sh_x[i] <= HIDE;
        r_sh_y[i] <= HIDE;
      end
    end else begin
      unique case (r_state)
        COLLECT: begin
          if (w_wr_fire) begin
            if (w_id_ok) begin
              for (int i = 0; i < NUM_OBJ; i++) begin
                if (wr_id == 5'(i)) begin
                  r_sh_x[i] <= wr_x;
                  r_sh_y[i] <= wr_y;
                end
              end
              if (wr_id == CUE_ID)
                r_sh_dir <= wr_dir;
            end else begin
              r_bad_id <= 1'b1;
            end
          end
          if (commit)
            r_state <= ARMED;
        end
        ARMED: begin
          if (w_vblank_start)
            r_state <= SWAP;
        end
        SWAP: begin
          // shadow is kept so software only rewrites moved objects
          for (int i = 0; i < NUM_OBJ; i++) begin
            r_pos_x[i*COORD_W +: COORD_W] <= r_sh_x[i];
            r_pos_y[i*COORD_W +: COORD_W] <= r_sh_y[i];
          end
          r_dir    <= r_sh_dir;
          r_hw_sig <= ~r_hw_sig;
          r_state  <= COLLECT;
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  assign wr_ready  = (r_state == COLLECT);
  assign pending   = (r_state == ARMED);
  assign pos_x     = r_pos_x;
  assign pos_y     = r_pos_y;
  assign direction = r_dir;
  assign hw_sig    = r_hw_sig;
  assign bad_id    = r_bad_id;

endmodule

// File: tb/tb_sprite_pos_writer.sv
// Directed bench for sprite_pos_writer: reset, swap latency,
// stall while armed, no-commit vblanks, bad id, mid-commit reset.
module tb_sprite_pos_writer;

  localparam int N = 17;
  localparam int W = 10;
  localparam logic [W-1:0] H = 10'h3FF;

  logic           clk;
  logic           reset_n;
  logic           wr_valid;
  logic           wr_ready;
  logic [4:0]     wr_id;
  logic [W-1:0]   wr_x;
  logic [W-1:0]   wr_y;
  logic [2:0]     wr_dir;
  logic           commit;
  logic [W-1:0]   draw_x;
  logic [W-1:0]   draw_y;
  logic [N*W-1:0] pos_x;
  logic [N*W-1:0] pos_y;
  logic [2:0]     direction;
  logic           hw_sig;
  logic           pending;
  logic           bad_id;

  int n_checks = 0;
  int n_err    = 0;

  logic [W-1:0] m_x [N];
  logic [W-1:0] m_y [N];
  logic [2:0]   m_dir;
  logic         m_hw;

  sprite_pos_writer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_id     (wr_id),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_dir    (wr_dir),
    .commit    (commit),
    .draw_x    (draw_x),
    .draw_y    (draw_y),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .direction (direction),
    .hw_sig    (hw_sig),
    .pending   (pending),
    .bad_id    (bad_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]   id;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [2:0]   dir;
    logic [W-1:0] ex;
    logic [W-1:0] ey;
    logic [2:0]   edir;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [191:0] got,
                     input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack(input logic [W-1:0] a [N]);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = a[i];
    return r;
  endfunction

  task automatic chk_model(input string name);
    chk({name, " pos_x"}, 192'(pos_x), 192'(pack(m_x)));
    chk({name, " pos_y"}, 192'(pos_y), 192'(pack(m_y)));
    chk({name, " dir"}, 192'(direction), 192'(m_dir));
    chk({name, " hw_sig"}, 192'(hw_sig), 192'(m_hw));
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_x[i] = H;
      m_y[i] = H;
    end
    m_dir = 3'd0;
    m_hw  = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] id, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [2:0] d,
                          input logic cm);
    int k;
    k = 0;
    while (!wr_ready && k < 20) begin
      tick();
      k++;
    end
    if (!wr_ready) begin
      n_checks++;
      n_err++;
      $display("FAIL write_wait: wr_ready stuck at 0, required 1");
    end
    wr_valid = 1'b1;
    wr_id = id;
    wr_x = x;
    wr_y = y;
    wr_dir = d;
    commit = cm;
    tick();
    wr_valid = 1'b0;
    commit = 1'b0;
  endtask

  // match for one cycle, then SWAP, then the edge that leaves SWAP
  task automatic vblank();
    draw_y = 10'd480;
    draw_x = 10'd0;
    tick();
    draw_x = 10'd1;
    tick();
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    wr_valid = 1'b0;
    wr_id = '0;
    wr_x = '0;
    wr_y = '0;
    wr_dir = '0;
    commit = 1'b0;
    draw_x = 10'd5;
    draw_y = 10'd10;
    model_reset();

    vecs[0] = '{5'd3,  10'd5,    10'd6,   3'd0, 10'd5,    10'd6,   3'd0};
    vecs[1] = '{5'd15, 10'd320,  10'd240, 3'd2, 10'd320,  10'd240, 3'd0};
    vecs[2] = '{5'd16, 10'd600,  10'd20,  3'd5, 10'd600,  10'd20,  3'd5};
    vecs[3] = '{5'd14, 10'd0,    10'd479, 3'd7, 10'd0,    10'd479, 3'd5};
    vecs[4] = '{5'd7,  10'd1022, 10'd1,   3'd1, 10'd1022, 10'd1,   3'd5};

    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    chk_model("reset");
    chk("reset wr_ready", 192'(wr_ready), 192'(1));
    chk("reset pending", 192'(pending), 192'(0));
    chk("reset bad_id", 192'(bad_id), 192'(0));

    // exact commit-to-active latency on slot 0
    do_write(5'd0, 10'd100, 10'd200, 3'd0, 1'b0);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("armed pending", 192'(pending), 192'(1));
    chk("armed wr_ready", 192'(wr_ready), 192'(0));
    draw_y = 10'd480;
    draw_x = 10'd0;
    tick();
    draw_x = 10'd1;
    chk("lat e1 slot0", 192'(pos_x[9:0]), 192'(H));
    tick();
    chk("lat e2 slot0", 192'(pos_x[9:0]), 192'(H));
    tick();
    m_x[0] = 10'd100;
    m_y[0] = 10'd200;
    m_hw = 1'b1;
    chk("lat e3 slot0 x", 192'(pos_x[9:0]), 192'(100));
    chk("lat e3 slot0 y", 192'(pos_y[9:0]), 192'(200));
    chk_model("lat e3");
    chk("lat e3 pending", 192'(pending), 192'(0));

    // table: write and commit in the same cycle, then vblank
    for (int v = 0; v < 5; v++) begin
      do_write(vecs[v].id, vecs[v].x, vecs[v].y, vecs[v].dir, 1'b1);
      vblank();
      m_x[vecs[v].id] = vecs[v].ex;
      m_y[vecs[v].id] = vecs[v].ey;
      m_dir = vecs[v].edir;
      m_hw = ~m_hw;
      chk($sformatf("vec%0d x", v),
          192'(pos_x[vecs[v].id*W +: W]), 192'(vecs[v].ex));
      chk($sformatf("vec%0d y", v),
          192'(pos_y[vecs[v].id*W +: W]), 192'(vecs[v].ey));
      chk($sformatf("vec%0d dir", v), 192'(direction), 192'(vecs[v].edir));
      chk_model($sformatf("vec%0d", v));
    end

    // write held during ARMED stalls until the edge leaving SWAP
    do_write(5'd2, 10'd11, 10'd12, 3'd0, 1'b1);
    wr_valid = 1'b1;
    wr_id = 5'd1;
    wr_x = 10'd50;
    wr_y = 10'd50;
    tick();
    chk("stall armed ready", 192'(wr_ready), 192'(0));
    draw_y = 10'd480;
    draw_x = 10'd0;
    tick();
    draw_x = 10'd1;
    tick();
    chk("stall swap ready", 192'(wr_ready), 192'(0));
    tick();
    chk("stall after ready", 192'(wr_ready), 192'(1));
    m_x[2] = 10'd11;
    m_y[2] = 10'd12;
    m_hw = ~m_hw;
    chk_model("stall swap");
    tick();
    wr_valid = 1'b0;
    chk("stall slot1 hidden", 192'(pos_x[W +: W]), 192'(H));
    do_write(5'd0, 10'd100, 10'd200, 3'd0, 1'b1);
    vblank();
    m_x[1] = 10'd50;
    m_y[1] = 10'd50;
    m_hw = ~m_hw;
    chk("stall slot1 x", 192'(pos_x[W +: W]), 192'(50));
    chk_model("stall commit");

    // vblanks without commit, one with the match held several cycles
    draw_y = 10'd480;
    draw_x = 10'd0;
    repeat (4) tick();
    draw_x = 10'd1;
    tick();
    vblank();
    chk_model("no commit");
    chk("no commit pending", 192'(pending), 192'(0));

    // out-of-range id
    do_write(5'd20, 10'd9, 10'd9, 3'd3, 1'b0);
    chk("bad_id set", 192'(bad_id), 192'(1));
    do_write(5'd20, 10'd9, 10'd9, 3'd3, 1'b1);
    vblank();
    m_hw = ~m_hw;
    chk_model("bad_id swap");
    chk("bad_id sticky", 192'(bad_id), 192'(1));

    // reset while armed discards the commit
    do_write(5'd16, 10'd7, 10'd8, 3'd3, 1'b1);
    chk("pre-reset pending", 192'(pending), 192'(1));
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    tick();
    model_reset();
    chk_model("mid reset");
    chk("mid reset pending", 192'(pending), 192'(0));
    chk("mid reset bad_id", 192'(bad_id), 192'(0));
    chk("mid reset ready", 192'(wr_ready), 192'(1));
    vblank();
    chk_model("post reset vblank");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
